// File: rtl/ham_secded_if.sv
// Stream interface of the SECDED decoder.
// Input side:  in_valid, in_ready, cw_in.
// Output side: out_valid, out_ready, data_out, syndrome, sgl_err, dbl_err.
// The decoder connects through the slave modport. The producer/consumer
// connects through the master modport.
interface ham_secded_if #(
    parameter int unsigned DATA_W = 4
);
    // Smallest R with 2^R >= d + R + 1.
    function automatic int unsigned calc_par_w(input int unsigned d);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < (d + r + 32'd1)) r = r + 1;
        return r;
    endfunction

    localparam int unsigned PAR_W = calc_par_w(DATA_W);
    localparam int unsigned CW_W  = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   cw_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [PAR_W-1:0]  syndrome;
    logic              sgl_err;
    logic              dbl_err;

    modport slave (
        input  in_valid, cw_in, out_ready,
        output in_ready, out_valid, data_out, syndrome, sgl_err, dbl_err
    );

    modport master (
        output in_valid, cw_in, out_ready,
        input  in_ready, out_valid, data_out, syndrome, sgl_err, dbl_err
    );
endinterface

// File: rtl/ham_secded_decoder.sv
// Pipelined SECDED (extended Hamming) decoder with a valid/ready stream.
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   bus       - stream interface (slave): codeword in; corrected data,
//               syndrome and error flags out, one cycle after accept
//   clr_cnt   - synchronous clear of both error counters
//   cor_cnt   - saturating count of words flagged sgl_err
//   unc_cnt   - saturating count of words flagged dbl_err
module ham_secded_decoder #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned OUT_INV = 0
) (
    input  logic              clk,
    input  logic              rst,
    ham_secded_if.slave       bus,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cor_cnt,
    output logic [CNT_W-1:0]  unc_cnt
);
    function automatic int unsigned calc_par_w(input int unsigned d);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < (d + r + 32'd1)) r = r + 1;
        return r;
    endfunction

    // Codeword position of data bit k: k-th non-power-of-two position from 3.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned pos;
        int unsigned cnt;
        pos = 0;
        cnt = 0;
        for (int unsigned q = 3; q < 128; q++) begin
            if ((q & (q - 32'd1)) != 0) begin
                if (cnt == k) pos = q;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    localparam int unsigned PAR_W = calc_par_w(DATA_W);
    localparam int unsigned CW_W  = DATA_W + PAR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [DATA_W-1:0] INV_MASK = (OUT_INV != 0) ? {DATA_W{1'b1}} : '0;

    logic [PAR_W-1:0]  syn;
    logic              op;
    logic              syn_zero;
    logic              in_range;
    logic              flip;
    logic              dec_sgl;
    logic              dec_dbl;
    logic [CW_W-1:0]   cw_fix;
    logic [DATA_W-1:0] dec_data;
    logic              accept;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // Syndrome and overall parity of the incoming codeword.
    always_comb begin
        syn = '0;
        for (int unsigned p = 1; p < CW_W; p++) begin
            if (bus.cw_in[p]) syn = syn ^ PAR_W'(p);
        end
        op = ^bus.cw_in;
    end

    // Syndromes beyond the last position only arise in shortened codes.
    assign syn_zero = (syn == '0);
    assign in_range = (syn <= PAR_W'(CW_W - 1));
    assign flip     = ~syn_zero & op & in_range;
    assign dec_sgl  = op & (syn_zero | in_range);
    assign dec_dbl  = ~syn_zero & (~op | ~in_range);
    assign cw_fix   = flip ? (bus.cw_in ^ (CW_W'(1) << syn)) : bus.cw_in;

    for (genvar k = 0; k < DATA_W; k++) begin : g_extract
        localparam int unsigned POS = data_pos(k);
        assign dec_data[k] = cw_fix[POS];
    end

    // Output stage: load on accept, drop valid once consumed, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.data_out  <= INV_MASK;
            bus.syndrome  <= '0;
            bus.sgl_err   <= 1'b0;
            bus.dbl_err   <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.data_out  <= dec_data ^ INV_MASK;
            bus.syndrome  <= syn;
            bus.sgl_err   <= dec_sgl;
            bus.dbl_err   <= dec_dbl;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Saturating error statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cor_cnt <= '0;
            unc_cnt <= '0;
        end else if (clr_cnt) begin
            cor_cnt <= '0;
            unc_cnt <= '0;
        end else if (accept) begin
            if (dec_sgl && cor_cnt != CNT_MAX) cor_cnt <= cor_cnt + CNT_W'(1);
            if (dec_dbl && unc_cnt != CNT_MAX) unc_cnt <= unc_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ham_secded_decoder.sv
// Directed self-checking bench for ham_secded_decoder.
// Three instances share one stimulus: default, CNT_W=2 and OUT_INV=1.
module tb_ham_secded_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_cnt = 1'b0;
    logic [7:0] cw = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ham_secded_if #(.DATA_W(4)) bus0 ();
    ham_secded_if #(.DATA_W(4)) bus1 ();
    ham_secded_if #(.DATA_W(4)) bus2 ();

    assign bus0.in_valid = in_valid;  assign bus0.cw_in = cw;  assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid;  assign bus1.cw_in = cw;  assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;  assign bus2.cw_in = cw;  assign bus2.out_ready = out_ready;

    logic [7:0] cor0, unc0, cor2, unc2;
    logic [1:0] cor1, unc1;

    ham_secded_decoder #(.DATA_W(4), .CNT_W(8), .OUT_INV(0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus0), .clr_cnt(clr_cnt), .cor_cnt(cor0), .unc_cnt(unc0));
    ham_secded_decoder #(.DATA_W(4), .CNT_W(2), .OUT_INV(0)) u_sat (
        .clk(clk), .rst(rst), .bus(bus1), .clr_cnt(clr_cnt), .cor_cnt(cor1), .unc_cnt(unc1));
    ham_secded_decoder #(.DATA_W(4), .CNT_W(8), .OUT_INV(1)) u_inv (
        .clk(clk), .rst(rst), .bus(bus2), .clr_cnt(clr_cnt), .cor_cnt(cor2), .unc_cnt(unc2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the main instance's result against a hand-decoded word.
    task automatic check_res(input string tag, input logic [3:0] data, input logic [2:0] syn,
                             input logic sgl, input logic dbl);
        check({tag, ".valid"}, 32'(bus0.out_valid), 32'd1);
        check({tag, ".data"},  32'(bus0.data_out),  32'(data));
        check({tag, ".syn"},   32'(bus0.syndrome),  32'(syn));
        check({tag, ".sgl"},   32'(bus0.sgl_err),   32'(sgl));
        check({tag, ".dbl"},   32'(bus0.dbl_err),   32'(dbl));
    endtask

    // Present one codeword for one edge (out_ready is high, so it is accepted).
    task automatic send(input logic [7:0] word);
        in_valid = 1'b1;
        cw = word;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check("rst.valid", 32'(bus0.out_valid), 32'd0);
        check("rst.data",  32'(bus0.data_out),  32'd0);
        check("rst.syn",   32'(bus0.syndrome),  32'd0);
        check("rst.sgl",   32'(bus0.sgl_err),   32'd0);
        check("rst.dbl",   32'(bus0.dbl_err),   32'd0);
        check("rst.cor",   32'(cor0), 32'd0);
        check("rst.unc",   32'(unc0), 32'd0);
        check("rst.inv_data", 32'(bus2.data_out), 32'hF);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean word and the three single/double-error classes
        send(8'hAA);
        check_res("clean", 4'hB, 3'd0, 1'b0, 1'b0);
        check("clean.cor", 32'(cor0), 32'd0);
        check("clean.unc", 32'(unc0), 32'd0);
        check("clean.inv_data", 32'(bus2.data_out), 32'h4);

        send(8'h8A);
        check_res("pos5", 4'hB, 3'd5, 1'b1, 1'b0);
        check("pos5.cor", 32'(cor0), 32'd1);

        send(8'hAB);
        check_res("bit0", 4'hB, 3'd0, 1'b1, 1'b0);
        check("bit0.cor", 32'(cor0), 32'd2);

        send(8'hE2);
        check_res("dbl", 4'hE, 3'd5, 1'b0, 1'b1);
        check("dbl.unc", 32'(unc0), 32'd1);
        check("dbl.cor", 32'(cor0), 32'd2);

        // Consumed with nothing new: valid drops
        @(posedge clk); #1;
        check("drain.valid", 32'(bus0.out_valid), 32'd0);
        check("drain.in_ready", 32'(bus0.in_ready), 32'd1);

        // Back-to-back stream with a 3-cycle downstream stall
        send(8'hAA);
        check_res("str0", 4'hB, 3'd0, 1'b0, 1'b0);
        in_valid = 1'b1;
        cw = 8'h8A;
        out_ready = 1'b0;
        #1;
        check("stall.in_ready", 32'(bus0.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_res("stall", 4'hB, 3'd0, 1'b0, 1'b0);
            check("stall.in_ready_hold", 32'(bus0.in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_res("str1", 4'hB, 3'd5, 1'b1, 1'b0);
        cw = 8'hE2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_res("str2", 4'hE, 3'd5, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("str.end_valid", 32'(bus0.out_valid), 32'd0);
        check("str.cor", 32'(cor0), 32'd3);
        check("str.unc", 32'(unc0), 32'd2);

        // Clear, then saturate the 2-bit counter
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check("clr.cor0", 32'(cor0), 32'd0);
        check("clr.unc0", 32'(unc0), 32'd0);
        check("clr.cor1", 32'(cor1), 32'd0);
        check("clr.valid", 32'(bus0.out_valid), 32'd0);
        in_valid = 1'b1;
        cw = 8'h8A;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            check("sat.cor1", 32'(cor1), (i > 3) ? 32'd3 : 32'(i));
        end
        check("sat.cor0", 32'(cor0), 32'd6);
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        in_valid = 1'b0;
        check("satclr.cor1", 32'(cor1), 32'd0);
        check("satclr.cor0", 32'(cor0), 32'd0);
        check_res("satclr", 4'hB, 3'd5, 1'b1, 1'b0);

        // Async reset while a result is held under backpressure
        send(8'h8A);
        check("prerst.cor", 32'(cor0), 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        cw = 8'hE2;
        @(posedge clk); #2;
        check("prerst.valid", 32'(bus0.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("arst.valid", 32'(bus0.out_valid), 32'd0);
        check("arst.cor",   32'(cor0), 32'd0);
        check("arst.unc",   32'(unc0), 32'd0);
        check("arst.data",  32'(bus0.data_out), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("postrst.valid", 32'(bus0.out_valid), 32'd0);
        send(8'hAA);
        check_res("postrst", 4'hB, 3'd0, 1'b0, 1'b0);
        check("postrst.inv_data", 32'(bus2.data_out), 32'h4);
        check("postrst.cor", 32'(cor0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ham_secded_decoder.md
Name: ham_secded_decoder

Overview:
Parametrised, pipelined SECDED (extended Hamming) decoder with a valid/ready stream interface. It accepts one codeword per cycle and returns corrected data, the syndrome and single/double-error flags one cycle later. Saturating error counters feed the board display/status logic. It generalises the fixed 7-bit combinational decoder to any data width, adds double-error detection, flow control and error statistics.

Parameters:
DATA_W, 4, data bits per word (1..57)
CNT_W, 8, width of each saturating error counter
OUT_INV, 0, 1 = data_out driven bitwise inverted (for active-low LED outputs)
Derived, not overridable: PAR_W = smallest R with 2^R >= DATA_W+R+1; CW_W = DATA_W+PAR_W+1 (DATA_W=4 gives PAR_W=3, CW_W=8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  codeword valid
in_ready  out  1  decoder can accept
cw_in  in  CW_W  codeword: bit 0 = overall parity; bit p (1..CW_W-1) = Hamming position p
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
data_out  out  DATA_W  corrected data (inverted when OUT_INV=1)
syndrome  out  PAR_W  Hamming syndrome of the accepted word
sgl_err  out  1  single error detected and corrected
dbl_err  out  1  uncorrectable error detected
clr_cnt  in  1  synchronous clear of both counters
cor_cnt  out  CNT_W  count of words flagged sgl_err
unc_cnt  out  CNT_W  count of words flagged dbl_err

Behaviour:
- Reset (async assert, released synchronously to clk by the top level): out_valid=0, data_out=0 (all ones if OUT_INV=1), syndrome=0, sgl_err=0, dbl_err=0, cor_cnt=0, unc_cnt=0.
- Code layout: parity bits sit at positions 1,2,4,...,2^(PAR_W-1). Data bit k sits at the k-th non-power-of-two position counting up from 3 (DATA_W=4: d0..d3 at 3,5,6,7).
- Syndrome s = XOR of indices p in 1..CW_W-1 where cw_in[p]=1. Overall parity op = XOR of all CW_W bits.
- Classification:
  - s=0, op=0: clean; flags 0.
  - s=0, op=1: bit 0 is in error; sgl_err=1; data unchanged.
  - s!=0, op=1, s<=CW_W-1: single error; flip position s; sgl_err=1.
  - s!=0, op=1, s>CW_W-1 (only possible with shortened codes): dbl_err=1; data uncorrected.
  - s!=0, op=0: dbl_err=1; data extracted uncorrected.
  - sgl_err and dbl_err are never both 1.
- Handshake: accept = in_valid & in_ready, with in_ready = ~out_valid | out_ready (no combinational in_valid->in_ready path).
  - On accept: output registers load the decode of cw_in; out_valid=1 next cycle. Latency is 1 cycle.
  - out_valid & out_ready & ~accept: out_valid clears next cycle.
  - out_valid & ~out_ready: all outputs hold stable; in_ready=0.
  - Throughput is 1 word/cycle while out_ready=1.
- Counters: updated on accept. cor_cnt+1 if the word's sgl_err=1; unc_cnt+1 if its dbl_err=1. Each saturates at 2^CNT_W-1 with no wrap. clr_cnt has priority over a same-cycle increment (result 0). clr_cnt does not affect the datapath.
- Reset mid-transfer drops any held result; no word is replayed.

Test Plan:
- DATA_W=4, cw_in=8'hAA, out_ready=1 -> next cycle out_valid=1, data_out=4'hB, syndrome=3'd0, sgl_err=0, dbl_err=0; counters unchanged.
- cw_in=8'h8A (position 5 flipped) -> data_out=4'hB, syndrome=3'd5, sgl_err=1, cor_cnt=1. cw_in=8'hAB (bit 0 flipped) -> data_out=4'hB, syndrome=0, sgl_err=1, cor_cnt=2.
- cw_in=8'hE2 (positions 3 and 6 flipped) -> syndrome=3'd5, dbl_err=1, sgl_err=0, data_out=4'hE (uncorrected), unc_cnt=1.
- Back-to-back stream of 8'hAA, 8'h8A, 8'hE2 with out_ready low for 3 cycles after the first result -> in_ready=0 and outputs frozen while stalled; all three results delivered in order, none lost or duplicated.
- CNT_W=2, six consecutive single-error words -> cor_cnt reaches 3 and holds. Assert clr_cnt together with a seventh single-error accept -> cor_cnt=0.
- Assert rst while out_valid=1 and out_ready=0 -> out_valid=0 and counters 0 immediately (async); first word after release decodes normally. OUT_INV=1 with 8'hAA -> data_out=4'h4.
